// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// fixed DWIDTH+3 cycle occupancy with a start/busy/done handshake.
module muldiv_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        sel,
    input  logic [DWIDTH-1:0] src1,
    input  logic [DWIDTH-1:0] src2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] res,
    output logic              res_is_0
);

    localparam int CW = $clog2(DWIDTH);
    localparam logic [DWIDTH-1:0] ALL_ONES = {DWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [CW-1:0]     LAST_STEP = CW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [2:0]            op_r;
    logic [DWIDTH-1:0]     src1_r, src2_r, mag_r, res_r;
    logic [2*DWIDTH-1:0]   acc_r;
    logic [CW-1:0]         cnt_r;
    logic                  neg_a_r, neg_b_r;

    logic                  signed_a_s, signed_b_s;
    logic [DWIDTH-1:0]     a_mag_s, b_mag_s;
    logic [DWIDTH:0]       sum_s, shifted_s, diff_s;
    logic [2*DWIDTH-1:0]   prod_s;
    logic [DWIDTH-1:0]     quo_s, rem_s, fix_res_s;
    logic                  div_zero_s, ovf_s;

    // Operand signedness and magnitudes at the accepting edge
    always_comb begin
        signed_a_s = (sel != 3'b011) && (sel != 3'b101) && (sel != 3'b111);
        signed_b_s = (sel == 3'b000) || (sel == 3'b001) || (sel == 3'b100) || (sel == 3'b110);
        a_mag_s    = (signed_a_s && src1[DWIDTH-1]) ? (~src1 + 1'b1) : src1;
        b_mag_s    = (signed_b_s && src2[DWIDTH-1]) ? (~src2 + 1'b1) : src2;
    end

    // One iteration: multiply adds into the high half and shifts right;
    // divide shifts the dividend into the partial remainder and trial-subtracts
    always_comb begin
        sum_s     = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]} + {1'b0, (acc_r[0] ? mag_r : {DWIDTH{1'b0}})};
        shifted_s = acc_r[2*DWIDTH-1:DWIDTH-1];
        diff_s    = shifted_s - {1'b0, mag_r};
    end

    // Sign correction, special cases and result select
    always_comb begin
        prod_s     = (neg_a_r ^ neg_b_r) ? (~acc_r + 1'b1) : acc_r;
        quo_s      = (neg_a_r ^ neg_b_r) ? (~acc_r[DWIDTH-1:0] + 1'b1) : acc_r[DWIDTH-1:0];
        rem_s      = neg_a_r ? (~acc_r[2*DWIDTH-1:DWIDTH] + 1'b1) : acc_r[2*DWIDTH-1:DWIDTH];
        div_zero_s = (src2_r == {DWIDTH{1'b0}});
        ovf_s      = (src1_r == MOST_NEG) && (src2_r == ALL_ONES);
        fix_res_s  = {DWIDTH{1'b0}};
        case (op_r)
            3'b000:                 fix_res_s = prod_s[DWIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*DWIDTH-1:DWIDTH];
            3'b100:  fix_res_s = div_zero_s ? ALL_ONES : (ovf_s ? MOST_NEG : quo_s);
            3'b101:  fix_res_s = div_zero_s ? ALL_ONES : acc_r[DWIDTH-1:0];
            3'b110:  fix_res_s = div_zero_s ? src1_r : (ovf_s ? {DWIDTH{1'b0}} : rem_s);
            3'b111:  fix_res_s = div_zero_s ? src1_r : acc_r[2*DWIDTH-1:DWIDTH];
            default: fix_res_s = {DWIDTH{1'b0}};
        endcase
    end

    // Next-state logic; flush returns any in-flight op to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !flush) state_nxt_s = CALC;
                else                 state_nxt_s = IDLE;
            end
            CALC: begin
                if (flush)                   state_nxt_s = IDLE;
                else if (cnt_r == LAST_STEP) state_nxt_s = FIX;
                else                         state_nxt_s = CALC;
            end
            FIX:     state_nxt_s = flush ? IDLE : DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            op_r    <= 3'b000;
            src1_r  <= {DWIDTH{1'b0}};
            src2_r  <= {DWIDTH{1'b0}};
            mag_r   <= {DWIDTH{1'b0}};
            acc_r   <= {(2*DWIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            res_r   <= {DWIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE && start && !flush) begin
                op_r    <= sel;
                src1_r  <= src1;
                src2_r  <= src2;
                neg_a_r <= signed_a_s & src1[DWIDTH-1];
                neg_b_r <= signed_b_s & src2[DWIDTH-1];
                mag_r   <= sel[2] ? b_mag_s : a_mag_s;
                acc_r   <= {{DWIDTH{1'b0}}, (sel[2] ? a_mag_s : b_mag_s)};
                cnt_r   <= {CW{1'b0}};
            end else if (state_r == CALC) begin
                cnt_r <= cnt_r + 1'b1;
                if (!op_r[2])       acc_r <= {sum_s, acc_r[DWIDTH-1:1]};
                else if (!diff_s[DWIDTH]) acc_r <= {diff_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b1};
                else                acc_r <= {shifted_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b0};
            end else if (state_r == FIX && !flush) begin
                res_r <= fix_res_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy     = (state_r != IDLE);
    assign done     = (state_r == DONE);
    assign res      = res_r;
    assign res_is_0 = (res_r == {DWIDTH{1'b0}});

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: every op class, special cases, latency, start
// filtering while busy, flush and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic [31:0] src1 = 32'h0;
    logic [31:0] src2 = 32'h0;
    logic        flush = 1'b0;
    logic        busy, done, res_is_0;
    logic [31:0] res;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .src1(src1), .src2(src2),
        .flush(flush), .busy(busy), .done(done), .res(res), .res_is_0(res_is_0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE; the accepting edge counts as edge 1, done must follow edge 34.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        logic busy_ok;
        start = 1'b1; sel = op; src1 = a; src2 = b;
        step();
        start = 1'b0; src1 = 32'h0; src2 = 32'h0;
        n = 1;
        busy_ok = busy;
        while (!done && n < 60) begin
            step();
            n++;
            busy_ok = busy_ok & busy;
        end
        chk({tag, "_lat"}, 32'(n), 32'd34);
        chk({tag, "_res"}, res, exp);
        chk({tag, "_zero"}, {31'd0, res_is_0}, {31'd0, (exp == 32'h0)});
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        step();
        chk({tag, "_done1"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", res, 32'h0);
        chk("rst_zero", {31'd0, res_is_0}, 32'd1);
        rst_n = 1'b1;
        step();

        run_op("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhu_min",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mul_wrap",   3'b000, 32'h80000000, 32'd2,        32'h0);
        run_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_op("divu",       3'b101, 32'd7,        32'd2,        32'd3);
        run_op("remu",       3'b111, 32'd7,        32'd2,        32'd1);
        run_op("div_by0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF);
        run_op("rem_by0",    3'b110, 32'd5,        32'd0,        32'd5);
        run_op("divu_by0",   3'b101, 32'd9,        32'd0,        32'hFFFFFFFF);
        run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);

        // start and operands churn while busy; only the captured 3*4 may complete
        start = 1'b1; sel = 3'b000; src1 = 32'd3; src2 = 32'd4;
        step();
        seen = 1;
        while (!done && seen < 60) begin
            start = ~start;
            sel = 3'($urandom_range(7, 0));
            src1 = $urandom;
            src2 = $urandom;
            step();
            seen++;
        end
        start = 1'b0;
        chk("churn_lat", 32'(seen), 32'd34);
        chk("churn_res", res, 32'd12);
        step();
        chk("churn_single_done", {31'd0, done}, 32'd0);
        run_op("after_churn", 3'b101, 32'd100, 32'd7, 32'd14);

        // flush ten cycles after accept
        run_op("pre_flush", 3'b000, 32'd6, 32'd7, 32'd42);
        start = 1'b1; sel = 3'b101; src1 = 32'd1000; src2 = 32'd3;
        step();
        start = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_res", res, 32'd42);
        seen = 0;
        repeat (40) begin
            step();
            if (done) seen++;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_res_held", res, 32'd42);

        // flush in IDLE blocks a simultaneous start
        start = 1'b1; flush = 1'b1; sel = 3'b000; src1 = 32'd2; src2 = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_block", {31'd0, busy}, 32'd0);

        // reset mid-CALC
        start = 1'b1; sel = 3'b000; src1 = 32'd5; src2 = 32'd5;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_res", res, 32'h0);
        seen = 0;
        repeat (40) begin
            step();
            if (done) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same register-bank operands as the ALU (src1 from rdata1, src2 from rdata2) and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles. A start/busy/done handshake stalls the pipeline. The result feeds the writeback mux alongside the ALU res.

Parameters:
DWIDTH, 32, operand/result width; must be even and >= 4

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; accepted only in IDLE
sel  input  3  op, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  input  DWIDTH  rs1 operand (multiplicand / dividend)
src2  input  DWIDTH  rs2 operand (multiplier / divisor)
flush  input  1  synchronous abort of any in-flight op
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; res valid in this cycle
res  output  DWIDTH  result, held until next accepted start
res_is_0  output  1  res == 0, combinational from res

Behaviour:
- Clock and reset: one clock (clk); reset synchronous active-low (rst_n). On a rising edge with rst_n=0: state=IDLE, busy=0, done=0, res=0, all internal registers 0. Reset wins over start and flush, including mid-operation; no done pulse follows.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on an edge with start=1 and flush=0. sel, src1 and src2 are captured on this edge; later input changes are ignored.
  - CALC runs exactly DWIDTH cycles. Step counter 0..DWIDTH-1. Operands are magnitudes. Multiply is radix-2 shift-add into a 2*DWIDTH product. Divide is restoring shift-subtract producing quotient and remainder.
  - CALC -> FIX when counter = DWIDTH-1.
  - FIX, 1 cycle: sign correction and result select, with res registered on exit.
  - FIX -> DONE.
  - DONE, 1 cycle: done=1. DONE -> IDLE.
- Latency: fixed for all ops and operand values. done=1 in the cycle after the (DWIDTH+2)th rising edge following the accepting edge (34 edges for DWIDTH=32). Back-to-back throughput is one op per DWIDTH+3 cycles.
- start in CALC, FIX or DONE is ignored; there is no queuing.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats src1 as signed and src2 as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
- Result select:
  - MUL returns the low DWIDTH bits of the product.
  - MULH, MULHSU and MULHU return the high DWIDTH bits.
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
- Signed division rules:
  - Quotient is truncated toward zero.
  - Remainder sign equals dividend sign.
- Special cases (value-checked in FIX; latency unchanged):
  - Divide by zero: DIV and DIVU return all ones; REM and REMU return src1.
  - Signed overflow (src1 = most-negative, src2 = all ones): DIV returns most-negative; REM returns 0.
- flush=1 in any non-IDLE state: next state is IDLE, no done pulse, res unchanged. flush in IDLE blocks acceptance of a simultaneous start.
- res is only updated on exit from FIX; it is never partial or glitching between ops.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD -> res 0xFFFFFFEB; done high exactly 34 edges after accept and for one cycle only; busy high throughout, low the cycle after done.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x80000000*2 -> 0, res_is_0=1.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 7/2 -> 3. REMU 7/2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0, res_is_0=1. All cases keep 34-edge latency.
- Start MUL 3*4; toggle start and change src1/src2 every cycle while busy -> only res=12, single done. Then issue a new op in IDLE the cycle after done -> accepted.
- Flush 10 cycles after accept -> busy=0 next cycle, no done, res keeps its prior value. rst_n=0 for one edge mid-CALC -> busy=0, res=0, no done pulse.
